// File: rtl/gray_counter_sched_pkg.sv
// rtl/gray_counter_sched_pkg.sv - op and FSM state types for the shared Gray counter scheduler
package gray_counter_sched_pkg;

  typedef enum logic [1:0] {
    OP_INC    = 2'd0,
    OP_DEC    = 2'd1,
    OP_LDBIN  = 2'd2,
    OP_LDGRAY = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first valid request at or after ptr, with wrap
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j[IDXW-1:0];
      end
    end
  end

endmodule

// File: rtl/gray_counter_sched.sv
// rtl/gray_counter_sched.sv - round-robin scheduler sharing one GrayCounter among NREQ requesters
module gray_counter_sched
  import gray_counter_sched_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int NREQ     = 4,
  parameter int SATURATE = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]      resp_bin,
  output logic [WIDTH-1:0]      resp_gray,
  output logic                  resp_err,
  output logic                  increment__ENA,
  input  logic                  increment__RDY,
  output logic                  decrement__ENA,
  input  logic                  decrement__RDY,
  output logic                  writeBin__ENA,
  output logic [WIDTH-1:0]      writeBin_v,
  input  logic                  writeBin__RDY,
  output logic                  writeGray__ENA,
  output logic [WIDTH-1:0]      writeGray_v,
  input  logic                  writeGray__RDY,
  input  logic [WIDTH-1:0]      readBin,
  input  logic [WIDTH-1:0]      readGray
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           state;
  state_t           state_nxt;
  logic [IDXW-1:0]  rr_ptr;
  logic [IDXW-1:0]  ptr_nxt;
  logic [IDXW-1:0]  idx_q;
  op_t              op_q;
  logic [WIDTH-1:0] data_q;
  logic             err_q;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             err_hold;

  logic [NREQ-1:0]  grant;
  logic [IDXW-1:0]  grant_idx;
  logic             found;
  op_t              sel_op;
  logic [WIDTH-1:0] sel_data;
  logic             op_rdy;
  logic             sat;
  logic             issuing;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .found (found)
  );

  always_comb begin
    sel_op   = OP_INC;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == i[IDXW-1:0]) begin
        sel_op   = op_t'(req_op[2*i +: 2]);
        sel_data = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  assign ptr_nxt = (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    case (op_q)
      OP_INC:    op_rdy = increment__RDY;
      OP_DEC:    op_rdy = decrement__RDY;
      OP_LDBIN:  op_rdy = writeBin__RDY;
      OP_LDGRAY: op_rdy = writeGray__RDY;
      default:   op_rdy = 1'b0;
    endcase
  end

  // A suppressed op still completes through CAPTURE so the requester gets resp_err.
  always_comb begin
    sat = 1'b0;
    if (SATURATE != 0) begin
      if (op_q == OP_INC && readBin == ALL_ONES) sat = 1'b1;
      if (op_q == OP_DEC && readBin == '0)       sat = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr   <= '0;
      idx_q    <= '0;
      op_q     <= OP_INC;
      data_q   <= '0;
      err_q    <= 1'b0;
      bin_q    <= '0;
      gray_q   <= '0;
      err_hold <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            idx_q  <= grant_idx;
            op_q   <= sel_op;
            data_q <= sel_data;
            rr_ptr <= ptr_nxt;
          end
        end
        ISSUE:   err_q <= sat;
        CAPTURE: begin
          bin_q    <= readBin;
          gray_q   <= readGray;
          err_hold <= err_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   if (sat || op_rdy) state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Responses are live from the counter during CAPTURE, then held by the registers.
  always_comb begin
    issuing        = (state == ISSUE) && !RST && !sat;
    req_ready      = '0;
    resp_valid     = '0;
    increment__ENA = 1'b0;
    decrement__ENA = 1'b0;
    writeBin__ENA  = 1'b0;
    writeGray__ENA = 1'b0;
    writeBin_v     = '0;
    writeGray_v    = '0;
    if (state == IDLE && !RST) req_ready = grant;
    if (state == CAPTURE && !RST) resp_valid[idx_q] = 1'b1;
    if (issuing) begin
      case (op_q)
        OP_INC:    increment__ENA = increment__RDY;
        OP_DEC:    decrement__ENA = decrement__RDY;
        OP_LDBIN: begin
          writeBin__ENA = writeBin__RDY;
          writeBin_v    = data_q;
        end
        OP_LDGRAY: begin
          writeGray__ENA = writeGray__RDY;
          writeGray_v    = data_q;
        end
        default: ;
      endcase
    end
    resp_bin  = (state == CAPTURE) ? readBin  : bin_q;
    resp_gray = (state == CAPTURE) ? readGray : gray_q;
    resp_err  = (state == CAPTURE) ? err_q    : err_hold;
  end

endmodule

// File: tb/tb_gray_counter_sched.sv
// tb/tb_gray_counter_sched.sv - scoreboard bench: wrapping and saturating schedulers on one stimulus stream
module tb_gray_counter_sched;

  localparam int W = 10;
  localparam int N = 4;

  typedef struct {
    int           idx;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         err;
    int           cyc;
  } exp_t;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           cnt_rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [2*N-1:0] req_op = '0;
  logic [W*N-1:0] req_data = '0;
  logic           inc_rdy = 1'b1;
  logic           dec_rdy = 1'b1;
  logic           wb_rdy = 1'b1;
  logic           wg_rdy = 1'b1;

  logic [N-1:0] req_ready0, resp_valid0, req_ready1, resp_valid1;
  logic [W-1:0] resp_bin0, resp_gray0, resp_bin1, resp_gray1;
  logic         resp_err0, resp_err1;
  logic         inc0, dec0, wb0, wg0, inc1, dec1, wb1, wg1;
  logic [W-1:0] wbv0, wgv0, wbv1, wgv1;
  logic [W-1:0] cb0, cb1, cg0, cg1;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   asserts = 0;
  int   fails = 0;
  int   both_n = 0;
  int   ena_n[2] = '{0, 0};
  int   ena_cyc[2] = '{0, 0};
  int   ena_kind[2] = '{0, 0};

  logic [W-1:0] four_bin[4]  = '{10'd1, 10'd2, 10'd3, 10'd4};
  logic [W-1:0] four_gray[4] = '{10'd1, 10'd3, 10'd2, 10'd6};

  gray_counter_sched #(.WIDTH(W), .NREQ(N), .SATURATE(0)) dut0 (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready0), .resp_valid(resp_valid0), .resp_bin(resp_bin0),
    .resp_gray(resp_gray0), .resp_err(resp_err0),
    .increment__ENA(inc0), .increment__RDY(inc_rdy),
    .decrement__ENA(dec0), .decrement__RDY(dec_rdy),
    .writeBin__ENA(wb0), .writeBin_v(wbv0), .writeBin__RDY(wb_rdy),
    .writeGray__ENA(wg0), .writeGray_v(wgv0), .writeGray__RDY(wg_rdy),
    .readBin(cb0), .readGray(cg0)
  );

  gray_counter_sched #(.WIDTH(W), .NREQ(N), .SATURATE(1)) dut1 (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready1), .resp_valid(resp_valid1), .resp_bin(resp_bin1),
    .resp_gray(resp_gray1), .resp_err(resp_err1),
    .increment__ENA(inc1), .increment__RDY(inc_rdy),
    .decrement__ENA(dec1), .decrement__RDY(dec_rdy),
    .writeBin__ENA(wb1), .writeBin_v(wbv1), .writeBin__RDY(wb_rdy),
    .writeGray__ENA(wg1), .writeGray_v(wgv1), .writeGray__RDY(wg_rdy),
    .readBin(cb1), .readGray(cg1)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Behavioural GrayCounter attached to each scheduler.
  assign cg0 = cb0 ^ (cb0 >> 1);
  assign cg1 = cb1 ^ (cb1 >> 1);

  always @(posedge CLK) begin
    if (cnt_rst) cb0 <= '0;
    else if (inc0 && !dec0) cb0 <= cb0 + 1'b1;
    else if (dec0 && !inc0) cb0 <= cb0 - 1'b1;
    else if (wb0) cb0 <= wbv0;
    else if (wg0) cb0 <= g2b(wgv0);
  end

  always @(posedge CLK) begin
    if (cnt_rst) cb1 <= '0;
    else if (inc1 && !dec1) cb1 <= cb1 + 1'b1;
    else if (dec1 && !inc1) cb1 <= cb1 - 1'b1;
    else if (wb1) cb1 <= wbv1;
    else if (wg1) cb1 <= g2b(wgv1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    asserts++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_resp(input int d, input logic [N-1:0] v, input logic [W-1:0] b,
                            input logic [W-1:0] g, input logic e);
    exp_t x;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      asserts++;
      fails++;
      $display("FAIL unexpected_resp dut%0d actual=%b required=none", d, v);
      return;
    end
    if (d == 0) x = q0.pop_front();
    else        x = q1.pop_front();
    check($sformatf("resp_valid%0d", d), 32'(v), 32'(1) << x.idx);
    check($sformatf("resp_bin%0d", d), 32'(b), 32'(x.bin));
    check($sformatf("resp_gray%0d", d), 32'(g), 32'(x.gray));
    check($sformatf("resp_err%0d", d), 32'(e), 32'(x.err));
    check($sformatf("resp_cycle%0d", d), 32'(cyc), 32'(x.cyc));
  endtask

  always @(negedge CLK) begin
    if (inc0 || dec0 || wb0 || wg0) begin
      ena_n[0]++;
      ena_cyc[0] = cyc;
      ena_kind[0] = inc0 ? 0 : dec0 ? 1 : wb0 ? 2 : 3;
    end
    if (inc1 || dec1 || wb1 || wg1) begin
      ena_n[1]++;
      ena_cyc[1] = cyc;
      ena_kind[1] = inc1 ? 0 : dec1 ? 1 : wb1 ? 2 : 3;
    end
    if ((inc0 && dec0) || (inc1 && dec1)) both_n++;
    if (resp_valid0 != '0) check_resp(0, resp_valid0, resp_bin0, resp_gray0, resp_err0);
    if (resp_valid1 != '0) check_resp(1, resp_valid1, resp_bin1, resp_gray1, resp_err1);
  end

  task automatic set_req(input int r, input logic [1:0] op, input logic [W-1:0] d);
    req_op[2*r +: 2]  = op;
    req_data[W*r +: W] = d;
    req_valid[r]       = 1'b1;
  endtask

  task automatic grant(input int r, input bit push, input int stall,
                       input logic [W-1:0] b0, input logic [W-1:0] g0, input logic e0,
                       input logic [W-1:0] b1, input logic [W-1:0] g1, input logic e1,
                       output int t);
    int   n;
    exp_t x;
    n = 0;
    t = -1;
    do begin
      @(negedge CLK);
      n++;
    end while (req_ready0 == '0 && n < 60);
    if (req_ready0 == '0) begin
      asserts++;
      fails++;
      $display("FAIL grant_timeout req=%0d actual=none required=ready", r);
      req_valid[r] = 1'b0;
      return;
    end
    t = cyc;
    check("req_ready0", 32'(req_ready0), 32'(1) << r);
    check("req_ready1", 32'(req_ready1), 32'(1) << r);
    if (push) begin
      x.idx = r; x.cyc = t + 2 + stall;
      x.bin = b0; x.gray = g0; x.err = e0;
      q0.push_back(x);
      x.bin = b1; x.gray = g1; x.err = e1;
      q1.push_back(x);
    end
    @(posedge CLK);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_op(input int r, input logic [1:0] op, input logic [W-1:0] d, input int stall,
                       input logic [W-1:0] b0, input logic [W-1:0] g0, input logic e0,
                       input logic [W-1:0] b1, input logic [W-1:0] g1, input logic e1);
    int t, n0, n1;
    n0 = ena_n[0];
    n1 = ena_n[1];
    if (stall > 0) wb_rdy = 1'b0;
    set_req(r, op, d);
    grant(r, 1'b1, stall, b0, g0, e0, b1, g1, e1, t);
    if (stall > 0) begin
      repeat (stall) @(posedge CLK);
      #1;
      wb_rdy = 1'b1;
    end
    drain();
    check("ena_count0", 32'(ena_n[0] - n0), 32'd1);
    check("ena_cycle0", 32'(ena_cyc[0]), 32'(t + 1 + stall));
    check("ena_kind0", 32'(ena_kind[0]), 32'(op));
    if (e1) begin
      check("ena_count1_sat", 32'(ena_n[1] - n1), 32'd0);
    end else begin
      check("ena_count1", 32'(ena_n[1] - n1), 32'd1);
      check("ena_cycle1", 32'(ena_cyc[1]), 32'(t + 1 + stall));
      check("ena_kind1", 32'(ena_kind[1]), 32'(op));
    end
  endtask

  task automatic reset_all();
    RST = 1'b1;
    cnt_rst = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    cnt_rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int t, t0, n0, n1, rc;
    req_valid = 4'b0001;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", 32'({req_ready0, req_ready1}), 32'd0);
    check("rst_resp_valid", 32'({resp_valid0, resp_valid1}), 32'd0);
    check("rst_ena", 32'({inc0, dec0, wb0, wg0, inc1, dec1, wb1, wg1}), 32'd0);
    check("rst_v0", 32'({wbv0, wgv0}), 32'd0);
    check("rst_v1", 32'({wbv1, wgv1}), 32'd0);
    check("rst_resp0", 32'({resp_err0, resp_bin0, resp_gray0}), 32'd0);
    check("rst_resp1", 32'({resp_err1, resp_bin1, resp_gray1}), 32'd0);
    @(posedge CLK);
    #1;
    req_valid = '0;
    RST = 1'b0;
    cnt_rst = 1'b0;

    do_op(0, 2'd0, 10'd0, 0, 10'd1, 10'd1, 1'b0, 10'd1, 10'd1, 1'b0);

    reset_all();
    for (int r = 0; r < N; r++) set_req(r, 2'd0, 10'd0);
    t0 = 0;
    for (int k = 0; k < N; k++) begin
      grant(k, 1'b1, 0, four_bin[k], four_gray[k], 1'b0, four_bin[k], four_gray[k], 1'b0, t);
      if (k == 0) t0 = t;
      else check("rr_spacing", 32'(t - t0), 32'(3 * k));
    end
    drain();

    do_op(1, 2'd2, 10'd1023, 0, 10'd1023, 10'd512, 1'b0, 10'd1023, 10'd512, 1'b0);
    do_op(2, 2'd0, 10'd0,    0, 10'd0,    10'd0,   1'b0, 10'd1023, 10'd512, 1'b1);
    do_op(3, 2'd3, 10'h3FF,  0, 10'h2AA,  10'h3FF, 1'b0, 10'h2AA,  10'h3FF, 1'b0);
    do_op(0, 2'd1, 10'd0,    0, 10'h2A9,  10'h3FD, 1'b0, 10'h2A9,  10'h3FD, 1'b0);
    do_op(1, 2'd2, 10'd0,    0, 10'd0,    10'd0,   1'b0, 10'd0,    10'd0,   1'b0);
    do_op(2, 2'd1, 10'd0,    0, 10'd1023, 10'd512, 1'b0, 10'd0,    10'd0,   1'b1);
    do_op(3, 2'd2, 10'd5,    4, 10'd5,    10'd7,   1'b0, 10'd5,    10'd7,   1'b0);

    wb_rdy = 1'b0;
    n0 = ena_n[0];
    n1 = ena_n[1];
    set_req(2, 2'd2, 10'd9);
    grant(2, 1'b0, 0, '0, '0, 1'b0, '0, '0, 1'b0, t);
    RST = 1'b1;
    set_req(3, 2'd0, 10'd0);
    set_req(0, 2'd0, 10'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    wb_rdy = 1'b1;
    rc = cyc;
    check("drop_ena0", 32'(ena_n[0] - n0), 32'd0);
    check("drop_ena1", 32'(ena_n[1] - n1), 32'd0);
    grant(0, 1'b1, 0, 10'd6, 10'd5, 1'b0, 10'd6, 10'd5, 1'b0, t);
    check("post_rst_accept", 32'(t), 32'(rc));
    grant(3, 1'b1, 0, 10'd7, 10'd4, 1'b0, 10'd7, 10'd4, 1'b0, t0);
    check("post_rst_next", 32'(t0 - t), 32'd3);
    drain();

    check("inc_dec_overlap", 32'(both_n), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/gray_counter_sched.md
# gray_counter_sched

Scheduler that shares one GrayCounter instance among NREQ requesters. Each requester issues increment, decrement, binary load or Gray load operations. The block grants them round-robin, drives the counter's client-side method enables one operation at a time, and returns the post-operation counter value to the granted requester. It sits between the pointer-management logic of multi-client FIFOs/trace units and the shared GrayCounter.

## Interface
Parameters:
- WIDTH, 10, counter width; must match the attached GrayCounter.
- NREQ, 4, number of requesters (2..8).
- SATURATE, 0, 1 = block increment at all-ones and decrement at zero.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request strobe; held until accepted.
- req_op  input  2*NREQ  per-requester op: 0 inc, 1 dec, 2 loadBin, 3 loadGray.
- req_data  input  WIDTH*NREQ  per-requester load value; ignored for inc/dec.
- req_ready  output  NREQ  one-hot accept pulse.
- resp_valid  output  NREQ  one-hot completion pulse.
- resp_bin  output  WIDTH  counter binary value after the op.
- resp_gray  output  WIDTH  counter Gray value after the op.
- resp_err  output  1  op suppressed by saturation; qualified by resp_valid.
- cnt  GrayCounterIfc#(width=WIDTH) client modport  shared counter connection.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - If any req_valid is set, the arbiter picks requester g, the first valid at or after rr_ptr, scanning upward with wrap.
  - Pulse req_ready[g] and latch g, op and data.
  - Advance rr_ptr to g+1 mod NREQ, then go to ISSUE.
- ISSUE: assert exactly one of increment__ENA, decrement__ENA, writeBin__ENA, writeGray__ENA, with the latched data on the matching $v.
  - Hold in ISSUE while that method's __RDY is low; ENA is asserted only in the cycle where __RDY is high.
  - Then go to CAPTURE.
- Saturation (SATURATE=1): the check happens in ISSUE against readBin.
  - An inc at 2^WIDTH-1 or a dec at 0 drives no ENA, sets err, and goes to CAPTURE.
- CAPTURE:
  - Register readBin/readGray into resp_bin/resp_gray and err into resp_err.
  - Pulse resp_valid[g] and return to IDLE.
- Wrap (SATURATE=0): inc at all-ones returns 0; dec at 0 returns 2^WIDTH-1. Arithmetic stays in the counter; this block never computes values.
- increment__ENA and decrement__ENA are never high in the same cycle; the counter cancels simultaneous inc/dec, and that must not happen.
- Load data is forwarded unmodified; loadGray accepts any WIDTH-bit pattern.
- All other ENA and $v outputs are 0 when not issuing.

## Timing
- Accept to completion: 3 cycles minimum. req_ready is in cycle t, ENA in t+1, resp_valid in t+2; add one cycle per cycle __RDY is low.
- Maximum throughput is one op per 3 cycles; the next accept can occur in the cycle after resp_valid.
- resp_bin, resp_gray and resp_err hold their values until the next CAPTURE.
- Reset values:
  - req_ready, resp_valid, all ENA outputs, resp_err: 0.
  - resp_bin, resp_gray, $v outputs: 0.
  - state: IDLE; rr_ptr: 0.
- RST asserted in any state: next cycle is IDLE with no ENA and no resp_valid. In-flight ops are dropped without a response.
  - Counter contents are not reset by this block.
- A requester that drops req_valid before req_ready is simply not served; there is no queuing.

## Structure
- Package gray_counter_sched_pkg: op typedef (OP_INC, OP_DEC, OP_LDBIN, OP_LDGRAY), state typedef (IDLE, ISSUE, CAPTURE).
- Sub-module rr_arbiter#(NREQ): request vector plus pointer in, one-hot grant and index out. It is combinational; the pointer register lives in the parent.
- Top level holds the FSM, the latched op/data/index, and the response registers.

## Test plan
- Single inc from requester 0 on counter 0: req_ready[0] at t, increment__ENA at t+1, resp_valid[0] at t+2 with resp_bin=1, resp_gray=1.
- Requesters 0-3 all valid with inc, rr_ptr=0: grants in order 0,1,2,3, one per 3 cycles; responses resp_bin=1,2,3,4 and resp_gray=1,3,2,6.
- loadBin 1023 then inc, SATURATE=0: resp_bin=1023 (gray 512), then 0. With SATURATE=1 the inc gives resp_err=1, resp_bin=1023, and no increment__ENA observed.
- loadGray 0x3FF: resp_gray=0x3FF, resp_bin=0x2AA. A following dec gives resp_bin=0x2A9.
- Hold writeBin__RDY low 4 cycles during an ISSUE loadBin 5: ENA is asserted only when RDY rises, and resp_valid arrives 4 cycles later with resp_bin=5.
- RST pulsed during ISSUE with RDY low: no ENA, no resp_valid; IDLE next cycle; next grant goes to requester 0.
